// File: rtl/pipeline_memory_pkg.sv
// Shared definitions for the pipeline_memory responder: port FSM state
// encodings, the default bus width and the latency preload helper.
package pipeline_memory_pkg;

   localparam int MEM_WORD_SIZE = 16;
   localparam int CNT_BITS      = 3;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_WAIT = 2'd1,
      MEM_DONE = 2'd2
   } mem_state_t;

   // Value loaded into the latency counter when a request is accepted.
   function automatic logic [CNT_BITS-1:0] lat_preload(input int latency);
      return CNT_BITS'(latency - 1);
   endfunction

endpackage

// File: rtl/pipeline_memory_if.sv
// Request/address/ready handshake for the instruction and data ports.
// The data buses themselves are bidirectional and stay as plain inout ports
// on pipeline_memory so the tri-state drivers live next to the array.
interface pipeline_memory_if
   import pipeline_memory_pkg::*;
#(
   parameter int WORD_SIZE = MEM_WORD_SIZE
);
   logic                 i_read;
   logic                 i_write;
   logic [WORD_SIZE-1:0] i_address;
   logic                 i_ready;

   logic                 d_read;
   logic                 d_write;
   logic [WORD_SIZE-1:0] d_address;
   logic                 d_ready;

   modport master (
      output i_read, i_write, i_address,
      output d_read, d_write, d_address,
      input  i_ready, d_ready
   );

   modport slave (
      input  i_read, i_write, i_address,
      input  d_read, d_write, d_address,
      output i_ready, d_ready
   );
endinterface

// File: rtl/pipeline_memory_port_fsm.sv
// One memory port: accepts a request in IDLE, waits LATENCY cycles, then
// spends exactly one DONE cycle where it pulses ready and either enables the
// read drivers or asks the top level to commit the latched write.
//
//   state    | meaning
//   MEM_IDLE | no access pending, sampling req every edge
//   MEM_WAIT | access latched, counting down the latency
//   MEM_DONE | ready pulse; read data driven or write committed at edge end
module pipeline_memory_port_fsm
   import pipeline_memory_pkg::*;
#(
   parameter int WORD_SIZE = MEM_WORD_SIZE,
   parameter int ADDR_BITS = 8,
   parameter int LATENCY   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req,
   input  logic                 write,
   input  logic [ADDR_BITS-1:0] addr_in,
   input  logic [WORD_SIZE-1:0] wdata_in,
   output logic                 ready,
   output logic                 drive,
   output logic                 commit,
   output logic [ADDR_BITS-1:0] addr,
   output logic [WORD_SIZE-1:0] wdata
);

   localparam logic [CNT_BITS-1:0] CNT_LOAD = lat_preload(LATENCY);

   mem_state_t          state_q, state_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic                load;
   logic                kind_write;

   // State, latency counter and access latches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= MEM_IDLE;
         cnt_q      <= '0;
         addr       <= '0;
         wdata      <= '0;
         kind_write <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (load) begin
            addr       <= addr_in;
            kind_write <= write;
            if (write) wdata <= wdata_in;
         end
      end
   end

   // Next-state and counter update; WAIT leaves when the counter shows 1.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      unique case (state_q)
         MEM_IDLE: begin
            if (req) begin
               load    = 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = (LATENCY == 1) ? MEM_DONE : MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == 1) state_d = MEM_DONE;
         end
         MEM_DONE: state_d = MEM_IDLE;
         default:  state_d = MEM_IDLE;
      endcase
   end

   assign ready  = (state_q == MEM_DONE);
   assign drive  = ready && !kind_write;
   assign commit = ready && kind_write;

endmodule

// File: rtl/pipeline_memory.sv
// Dual-port word memory answering the CPU instruction (read-only) and data
// (read/write) buses. Each port runs its own latency FSM; the array is read
// combinationally during a port's DONE cycle and written at the edge that
// ends a data-port write DONE, so a same-cycle instruction read sees the old
// word. Optional build macro MEM_PROTECT_EN discards data writes below
// TEXT_LIMIT while still completing them with a normal ready pulse.
module pipeline_memory
   import pipeline_memory_pkg::*;
#(
   parameter int WORD_SIZE  = MEM_WORD_SIZE,
   parameter int ADDR_BITS  = 8,
   parameter int LATENCY    = 1,
   parameter int TEXT_LIMIT = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pipeline_memory_if.slave     bus,
   inout  wire [WORD_SIZE-1:0]  i_data,
   inout  wire [WORD_SIZE-1:0]  d_data
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [WORD_SIZE-1:0] mem [DEPTH];

   logic                 i_drive, d_drive, d_commit;
   logic [ADDR_BITS-1:0] i_addr, d_addr;
   logic [WORD_SIZE-1:0] d_wdata;
   logic                 write_ok;

   logic                 i_commit_unused;
   logic [WORD_SIZE-1:0] i_wdata_unused;
   logic                 unused_bits;

   // Instruction port never writes: i_write is ignored and a read request
   // alone decides acceptance.
   pipeline_memory_port_fsm #(
      .WORD_SIZE (WORD_SIZE),
      .ADDR_BITS (ADDR_BITS),
      .LATENCY   (LATENCY)
   ) u_i_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (bus.i_read),
      .write    (1'b0),
      .addr_in  (bus.i_address[ADDR_BITS-1:0]),
      .wdata_in ('0),
      .ready    (bus.i_ready),
      .drive    (i_drive),
      .commit   (i_commit_unused),
      .addr     (i_addr),
      .wdata    (i_wdata_unused)
   );

   // Data port: read and write together is treated as a write.
   pipeline_memory_port_fsm #(
      .WORD_SIZE (WORD_SIZE),
      .ADDR_BITS (ADDR_BITS),
      .LATENCY   (LATENCY)
   ) u_d_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (bus.d_read || bus.d_write),
      .write    (bus.d_write),
      .addr_in  (bus.d_address[ADDR_BITS-1:0]),
      .wdata_in (d_data),
      .ready    (bus.d_ready),
      .drive    (d_drive),
      .commit   (d_commit),
      .addr     (d_addr),
      .wdata    (d_wdata)
   );

`ifdef MEM_PROTECT_EN
   assign write_ok = ({{(32-ADDR_BITS){1'b0}}, d_addr} >= TEXT_LIMIT);
   assign unused_bits = ^{bus.i_write, bus.i_address, bus.d_address};
`else
   assign write_ok = 1'b1;
   assign unused_bits = ^{bus.i_write, bus.i_address, bus.d_address, TEXT_LIMIT[0]};
`endif

   // Array write at the edge that ends a data-port write DONE; no reset so
   // contents survive rst_n.
   always_ff @(posedge clk) begin
      if (d_commit && write_ok) mem[d_addr] <= d_wdata;
   end

   assign i_data = i_drive ? mem[i_addr] : {WORD_SIZE{1'bz}};
   assign d_data = d_drive ? mem[d_addr] : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_pipeline_memory.sv
// Directed bench for pipeline_memory at LATENCY=3. Undriven buses are
// pulled low so a released bus reads back as zero.
module tb_pipeline_memory;

   localparam int WS  = 16;
   localparam int AB  = 8;
   localparam int LAT = 3;
   localparam int TL  = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipeline_memory_if #(.WORD_SIZE(WS)) bus ();

   tri0 [WS-1:0] i_data_w;
   tri0 [WS-1:0] d_data_w;
   logic          tb_drive = 1'b0;
   logic [WS-1:0] tb_wdata = '0;
   assign d_data_w = tb_drive ? tb_wdata : {WS{1'bz}};

   pipeline_memory #(
      .WORD_SIZE  (WS),
      .ADDR_BITS  (AB),
      .LATENCY    (LAT),
      .TEXT_LIMIT (TL)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus.slave),
      .i_data (i_data_w),
      .d_data (d_data_w)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.i_read    = 1'b0;
      bus.i_write   = 1'b0;
      bus.i_address = '0;
      bus.d_read    = 1'b0;
      bus.d_write   = 1'b0;
      bus.d_address = '0;
      tb_drive      = 1'b0;
   endtask

   // One request on either or both ports, held for a single edge, then 12
   // cycles of observation. Latency k counts cycles after the accept edge.
   // 'stray' counts bus drive outside a read DONE and extra ready pulses.
   task automatic access(input logic ir, input logic iw, input logic dr, input logic dw,
                         input logic [WS-1:0] ia, input logic [WS-1:0] da, input logic [WS-1:0] wd,
                         output int ilat, output int dlat,
                         output logic [WS-1:0] ird, output logic [WS-1:0] drd,
                         output int stray);
      ilat = 0; dlat = 0; ird = '0; drd = '0; stray = 0;
      bus.i_read = ir; bus.i_write = iw; bus.i_address = ia;
      bus.d_read = dr; bus.d_write = dw; bus.d_address = da;
      tb_wdata = wd; tb_drive = dw;
      @(posedge clk); #1;
      idle_inputs();
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (bus.i_ready) begin
            if (ilat == 0) ilat = k; else stray++;
            ird = i_data_w;
         end else if (i_data_w !== '0) stray++;
         if (bus.d_ready) begin
            if (dlat == 0) dlat = k; else stray++;
            if (dr && !dw) drd = d_data_w;
            else if (d_data_w !== '0) stray++;
         end else if (d_data_w !== '0) stray++;
      end
      @(posedge clk); #1;
   endtask

   task automatic d_wr(input string tag, input logic [WS-1:0] a, input logic [WS-1:0] wd);
      int il, dl, st;
      logic [WS-1:0] ir_, dr_;
      access(1'b0, 1'b0, 1'b0, 1'b1, '0, a, wd, il, dl, ir_, dr_, st);
      check_val({tag, " d_lat"}, dl, LAT);
      check_val({tag, " stray"}, st, 0);
   endtask

   task automatic d_rd(input string tag, input logic [WS-1:0] a, output logic [WS-1:0] rd);
      int il, dl, st;
      logic [WS-1:0] ir_;
      access(1'b0, 1'b0, 1'b1, 1'b0, '0, a, '0, il, dl, ir_, rd, st);
      check_val({tag, " d_lat"}, dl, LAT);
      check_val({tag, " stray"}, st, 0);
   endtask

   task automatic i_rd(input string tag, input logic [WS-1:0] a, output logic [WS-1:0] rd);
      int il, dl, st;
      logic [WS-1:0] dr_;
      access(1'b1, 1'b0, 1'b0, 1'b0, a, '0, '0, il, dl, rd, dr_, st);
      check_val({tag, " i_lat"}, il, LAT);
      check_val({tag, " stray"}, st, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [WS-1:0] rd, base5, base20, ird, drd;
      int il, dl, st, pulses, leaks;

      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset i_ready", bus.i_ready, 0);
      check_val("reset d_ready", bus.d_ready, 0);
      check_val("reset i_data", i_data_w, 0);
      check_val("reset d_data", d_data_w, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset dropped mid-WAIT of a write to address 5.
      d_wr("pre5", 16'd5, 16'h0505);
      d_rd("base5", 16'd5, base5);
`ifndef MEM_PROTECT_EN
      check_val("base5 data", base5, 16'h0505);
`endif
      bus.d_write = 1'b1; bus.d_address = 16'd5; tb_wdata = 16'hBEEF; tb_drive = 1'b1;
      @(posedge clk); #1;
      idle_inputs();
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_val("rst mid d_ready", bus.d_ready, 0);
      check_val("rst mid i_ready", bus.i_ready, 0);
      check_val("rst mid d_data", d_data_w, 0);
      check_val("rst mid i_data", i_data_w, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus.d_ready) pulses++;
      end
      check_val("rst dropped pulse", pulses, 0);
      @(posedge clk); #1;
      d_rd("post rst", 16'd5, rd);
      check_val("rst mem5 kept", rd, base5);

      // Write then read at address 10.
      d_wr("wr10", 16'd10, 16'h1234);
      d_rd("rd10", 16'd10, rd);
      check_val("rd10 data", rd, 16'h1234);

      // Concurrent i-read and d-write to the same word.
      access(1'b1, 1'b0, 1'b0, 1'b1, 16'd10, 16'd10, 16'h5555, il, dl, ird, drd, st);
      check_val("coll i_lat", il, LAT);
      check_val("coll d_lat", dl, LAT);
      check_val("coll i old data", ird, 16'h1234);
      check_val("coll stray", st, 0);
      i_rd("coll after", 16'd10, rd);
      check_val("coll new data", rd, 16'h5555);

      // Read+write together with aliased address: write wins, no read drive.
      access(1'b0, 1'b0, 1'b1, 1'b1, '0, 16'h0103, 16'h00AA, il, dl, ird, drd, st);
      check_val("prio d_lat", dl, LAT);
      check_val("prio no drive", st, 0);
      d_rd("alias d", 16'd3, rd);
      check_val("alias d data", rd, 16'h00AA);
      i_rd("alias i", 16'hFF03, rd);
      check_val("alias i data", rd, 16'h00AA);

      // Write protection boundary around TEXT_LIMIT.
      i_rd("base20", 16'd20, base20);
      d_wr("wr20", 16'd20, 16'hFFFF);
      d_wr("wr64", 16'd64, 16'hFFFF);
      d_rd("rd64", 16'd64, rd);
      check_val("rd64 data", rd, 16'hFFFF);
      d_rd("rd20", 16'd20, rd);
`ifdef MEM_PROTECT_EN
      check_val("rd20 protected", rd, base20);
`else
      check_val("rd20 written", rd, 16'hFFFF);
`endif

      // i_write alone for 10 cycles: never accepted.
      bus.i_write = 1'b1; bus.i_address = 16'd10;
      pulses = 0; leaks = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.i_ready) pulses++;
         if (i_data_w !== '0) leaks++;
         @(posedge clk); #1;
      end
      idle_inputs();
      check_val("iwrite ready", pulses, 0);
      check_val("iwrite bus", leaks, 0);

      // Held d-read: one access per LATENCY+1 cycles, no re-accept in DONE.
      bus.d_read = 1'b1; bus.d_address = 16'd3;
      pulses = 0; leaks = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.d_ready) begin
            pulses++;
            if (d_data_w !== 16'h00AA) leaks++;
         end
         @(posedge clk); #1;
      end
      idle_inputs();
      check_val("held rd pulses", pulses, 3);
      check_val("held rd data", leaks, 0);
      repeat (6) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
